dlfloat16_addsub_arbiter: RTL and testbench

Shares one `dlfloat16_add_sub` datapath among `N_REQ` requesters. Each requester presents an operand pair and an op (add or sub) on a valid/ready channel. The arbiter grants one requester per cycle, drives the datapath operands from registers and tracks the unit's registered-output latency. Results return in issue order on one backpressured response channel, tagged with the requester ID.

---
 rtl/dlfloat16_addsub_arbiter.sv | 156 +++++++++++++++
 tb/tb_dlfloat16_addsub_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat16_addsub_arbiter.sv
// Shares one registered dlfloat16 add/sub datapath among N_REQ requesters.
// Round-robin grant by default; define DLF_ARB_FIXED_PRIO_EN for fixed priority.
module dlfloat16_addsub_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_op,
    output logic [15:0]          dp_a,
    output logic [15:0]          dp_b,
    output logic                 dp_op,
    input  logic [19:0]          dp_c_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [19:0]          rsp_data
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int ENT_W = ID_W + 20;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gnt_id;
    logic              found;
    logic              accept;
    logic              credit_ok;
    logic [CNT_W:0]    used;
    int                idx;

    logic              s0_v;
    logic              s1_v;
    logic [ID_W-1:0]   s0_id;
    logic [ID_W-1:0]   s1_id;

    logic [ENT_W-1:0]  mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;

`ifndef DLF_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   rr_ptr;
`endif

    // Operations in flight reserve a FIFO slot so a push never finds it full.
    assign used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(s0_v)
                + (CNT_W+1)'(s1_v);
    assign credit_ok = used < (CNT_W+1)'(RSP_DEPTH);

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (credit_ok && !rst) begin
            for (int k = 0; k < N_REQ; k++) begin
`ifdef DLF_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (int'(rr_ptr) + k) % N_REQ;
`endif
                if (!found && req_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_id     = ID_W'(idx);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = found;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_a  <= '0;
            dp_b  <= '0;
            dp_op <= 1'b0;
            s0_v  <= 1'b0;
            s1_v  <= 1'b0;
            s0_id <= '0;
            s1_id <= '0;
        end else begin
            if (accept) begin
                dp_a  <= req_a[16*gnt_id +: 16];
                dp_b  <= req_b[16*gnt_id +: 16];
                dp_op <= req_op[gnt_id];
                s0_id <= gnt_id;
            end
            s0_v  <= accept;
            s1_v  <= s0_v;
            s1_id <= s0_id;
        end
    end

`ifndef DLF_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (gnt_id == ID_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt_id + ID_W'(1);
            end
        end
    end
`endif

    assign push = s1_v;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < RSP_DEPTH; j++) begin
                mem[j] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s1_id, dp_c_out};
                if (wr_ptr == PTR_W'(RSP_DEPTH - 1)) begin
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            if (pop) begin
                if (rd_ptr == PTR_W'(RSP_DEPTH - 1)) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    assign rsp_valid          = fifo_count != '0;
    assign {rsp_id, rsp_data} = mem[rd_ptr];

endmodule

// File: tb/tb_dlfloat16_addsub_arbiter.sv
// Scoreboard bench for dlfloat16_addsub_arbiter with a registered stub datapath.
// Expectations follow DLF_ARB_FIXED_PRIO_EN when it is defined.
module tb_dlfloat16_addsub_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [N-1:0]  req_op;
    logic [15:0]   dp_a;
    logic [15:0]   dp_b;
    logic          dp_op;
    logic [19:0]   dp_c_out = '0;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [19:0]   rsp_data;

    logic [21:0]   q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_rsp = 0;

    dlfloat16_addsub_arbiter #(.N_REQ(4), .ID_W(2), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_c_out(dp_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) dp_c_out <= {dp_op, 3'b000, dp_a};

    function automatic logic [19:0] stub(logic op, logic [15:0] a);
        return {op, 3'b000, a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        req_valid = '0;
        q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        step();
        @(negedge clk);
        chk("drain_idle", 32'(rsp_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %h expected none",
                         {rsp_id, rsp_data});
            end else begin
                chk("rsp", 32'({rsp_id, rsp_data}), 32'(q.pop_front()));
                n_rsp++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        int acc;
        int base;

        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_dp", {dp_op, dp_b[6:0], dp_a}, 32'd0);
        step();
        rst = 1'b0;
        req_valid = '0;

        // Single request from requester 2
        req_valid = 4'b0100;
        req_a[47:32] = 16'h3E00;
        req_op[2] = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h4);
        q.push_back({2'd2, 20'h83E00});
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_lat0", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("single_lat1", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("single_lat2", 32'(rsp_valid), 32'd1);
        drain();

        // All four requesters continuously valid
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = 16'h4100 + 16'(i);
            req_op[i] = i[0];
        end
        req_valid = '1;
        g = 2'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << g));
            q.push_back({g, stub(req_op[g], req_a[16*g +: 16])});
`ifndef DLF_ARB_FIXED_PRIO_EN
            g = g + 2'd1;
`endif
            step();
        end
        req_valid = '0;
        drain();

        // Requesters 1 and 3 competing
        do_reset();
        rsp_ready = 1'b1;
        req_a[31:16] = 16'h6001;
        req_a[63:48] = 16'h6003;
        req_op = '0;
        req_valid = 4'b1010;
        g = 2'd1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("pri13_grant", 32'(req_ready), 32'(4'b0001 << g));
            q.push_back({g, stub(1'b0, req_a[16*g +: 16])});
`ifndef DLF_ARB_FIXED_PRIO_EN
            g = (g == 2'd1) ? 2'd3 : 2'd1;
`endif
            step();
        end
        req_valid = '0;
        drain();

        // Backpressure: requester 0 always valid, consumer stalled
        do_reset();
        rsp_ready = 1'b0;
        req_a[15:0] = 16'h2200;
        req_op[0] = 1'b0;
        req_valid = 4'b0001;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                acc++;
                q.push_back({2'd0, 20'h02200});
            end
            step();
        end
        chk("bp_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        chk("bp_stalled", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_valid", 32'(rsp_valid), 32'd1);
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_resume", 32'(req_ready), 32'h1);
        q.push_back({2'd0, 20'h02200});
        step();
        @(negedge clk);
        chk("bp_restall", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        drain();

        // Three in FIFO plus one in flight, then push and pop together
        do_reset();
        rsp_ready = 1'b0;
        base = n_rsp;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0010;
            req_a[31:16] = 16'h5000 + 16'(k);
            req_op[1] = k[0];
            @(negedge clk);
            chk("full_accept", 32'(req_ready), 32'h2);
            q.push_back({2'd1, stub(k[0], 16'h5000 + 16'(k))});
            step();
        end
        req_valid = '0;
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_valid0", 32'(rsp_valid), 32'd1);
        step();
        @(negedge clk);
        chk("full_valid1", 32'(rsp_valid), 32'd1);
        drain();
        chk("full_count", 32'(n_rsp - base), 32'd4);

        // Reset one cycle after an accept drops the operation
        do_reset();
        rsp_ready = 1'b1;
        req_a[31:16] = 16'h1234;
        req_op[1] = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rst_accept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_dropped", 32'(rsp_valid), 32'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
